// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: captures a WIDTH-bit word on a ready/valid
// handshake and shifts it out MSB first, optionally followed by GAP idle cycles.
module piso_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data_out,
  output logic             shift_en,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic             data_out_d, shift_en_d, frame_start_d, frame_done_d;
  logic             load_ready_d, busy_d;
  logic             accept;

  // load_ready is registered, so it stays low for one cycle after reset release.
  assign accept = (state == S_IDLE) && load_ready && load_valid;

  // NOTE: every register uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      data_out    <= 1'b0;
      shift_en    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      load_ready  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      sreg        <= sreg_d;
      cnt         <= cnt_d;
      gap_cnt     <= gap_cnt_d;
      data_out    <= data_out_d;
      shift_en    <= shift_en_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
      load_ready  <= load_ready_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_SHIFT;
      S_SHIFT: if (cnt == '0) next_state = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == '0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    sreg_d        = sreg;
    cnt_d         = cnt;
    gap_cnt_d     = gap_cnt;
    data_out_d    = 1'b0;
    shift_en_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    load_ready_d  = (next_state == S_IDLE);
    busy_d        = (next_state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          sreg_d        = load_data;
          cnt_d         = CNT_W'(WIDTH - 1);
          data_out_d    = load_data[WIDTH-1];
          shift_en_d    = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg << 1;
        if (cnt != '0) begin
          cnt_d        = cnt - 1'b1;
          data_out_d   = sreg[WIDTH-2];
          shift_en_d   = 1'b1;
          frame_done_d = (cnt == CNT_W'(1));
        end else if (GAP > 0) begin
          gap_cnt_d = GAP_W'(GAP - 1);
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_cnt_d = gap_cnt - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, serial frame length in bits; legal values 2..32.
REQ-002 Parameter GAP, default 0, idle cycles inserted after each frame before the next load is accepted; legal values 0..15.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load_valid  in  1  parallel word offered.
REQ-006 load_data  in  WIDTH  parallel word; sampled only on an accepted handshake.
REQ-007 load_ready  out  1  block can accept a word.
REQ-008 data_out  out  1  serial bit, MSB first, feeds the downstream serial-in/parallel-out register.
REQ-009 shift_en  out  1  data_out holds a valid frame bit this cycle.
REQ-010 frame_start  out  1  one-cycle pulse on the first bit of a frame.
REQ-011 frame_done  out  1  one-cycle pulse on the last bit of a frame.
REQ-012 busy  out  1  high in SHIFT or GAP.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and GAP; all outputs SHALL be registered.
REQ-014 A load SHALL be accepted at a rising edge E0 where load_valid=1 and load_ready=1; load_data SHALL be captured into the shift register and a bit counter SHALL be set to WIDTH-1.
REQ-015 After E0, the block SHALL be in SHIFT with data_out=load_data[WIDTH-1], shift_en=1 and frame_start=1.
REQ-016 After edge E0+i (0<=i<=WIDTH-1), data_out SHALL equal load_data[WIDTH-1-i]; the register SHALL shift left with zero fill and the counter SHALL decrement by one.
REQ-017 shift_en SHALL be high for exactly WIDTH consecutive cycles per frame; frame_done SHALL be high only after edge E0+WIDTH-1, coincident with the LSB.
REQ-018 At edge E0+WIDTH, the FSM SHALL enter GAP if GAP>0 (staying there for exactly GAP cycles), otherwise IDLE; shift_en, data_out, frame_start and frame_done SHALL then be 0.
REQ-019 load_ready SHALL be 1 only in IDLE; load_valid SHALL be ignored in SHIFT and GAP, with no capture and no state change.
REQ-020 Minimum accept-to-accept spacing SHALL be WIDTH+1+GAP cycles; back-to-back frames SHALL NOT overlap or drop bits.
REQ-021 data_out SHALL be 0 whenever shift_en=0.
REQ-022 For WIDTH=2, frame_start and frame_done SHALL occur on consecutive cycles; they SHALL never both be high in the same cycle for any legal WIDTH.

Reset
REQ-023 While rst=1, the FSM SHALL be IDLE, the shift register and counter SHALL be 0, and load_ready, data_out, shift_en, frame_start, frame_done and busy SHALL all be 0, independent of clk.
REQ-024 load_ready SHALL rise after the first rising edge following rst deassertion.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; no frame_done SHALL follow, and the partial word SHALL be discarded.

Verification
REQ-026 WIDTH=4, GAP=0: load 4'b1011 -> data_out 1,0,1,1 on four consecutive cycles with shift_en high; frame_start on bit 1 and frame_done on bit 4; a 4-bit shift register enabled by shift_en holds 4'b1011.
REQ-027 WIDTH=4, load_valid held high with words 4'hA then 4'h5 -> accepts exactly 5 cycles apart; serial stream 1010 0101; no bit lost.
REQ-028 Pulse load_valid with 4'hF while in SHIFT of a 4'h3 frame -> stream stays 0011; 4'hF is not captured; load_ready stays 0.
REQ-029 WIDTH=4, GAP=2: load 4'h9 -> 4 shift cycles, then 2 cycles with busy=1 and load_ready=0, then load_ready=1.
REQ-030 Assert rst asynchronously after bit 2 of 4'hC -> all outputs 0 immediately, no frame_done; after release, load 4'h6 -> stream 0110.
REQ-031 WIDTH=16: load 16'h8001 -> data_out 1, then 14 zeros, then 1; frame_done only on cycle 16.
